// File: rtl/bq_frame_tx_seq_pkg.sv
// Shared types and constants for the framed UART transmit sequencer.
package bq_frame_tx_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_DATA,
        ST_CRC_WAIT,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_DONE
    } state_e;

    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_REFL = 16'hA001;
    localparam int          MAX_LEN_DEF   = 16;

    // Reflected CRC-16/IBM advanced by one byte, bit 0 first.
    function automatic logic [15:0] crc16_ibm_byte(input logic [15:0] crc, input logic [7:0] din);
        logic [15:0] c;
        c = crc ^ {8'h00, din};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/bq_frame_tx_seq_crc16_ibm_d8.sv
// Byte-wide CRC-16/IBM register: init has priority over en, one byte per clock.
module crc16_ibm_d8
    import bq_frame_tx_seq_pkg::*;
(
    input  logic        sclk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;

    always_ff @(posedge sclk) begin
        if (!reset || init) begin
            crc_q <= CRC_INIT;
        end else if (en) begin
            crc_q <= crc16_ibm_byte(crc_q, din);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/bq_frame_tx_seq.sv
// Forwards a requester byte stream to a UART transmitter and appends a CRC-16/IBM trailer.
//   state     | meaning
//   IDLE      | waiting for s_valid, nothing consumed
//   INIT      | CRC preset, byte counter cleared
//   DATA      | forwarding frame bytes through the output register
//   CRC_WAIT  | last byte (or overflow) taken, waiting for output register to drain
//   CRC_LO    | presenting crc[7:0]
//   CRC_HI    | presenting crc[15:8]
//   DONE      | frame_done pulse
module bq_frame_tx_seq
    import bq_frame_tx_seq_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic        sclk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] crc_value
);

    localparam int             CW       = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(MAX_LEN - 1);

    state_e         state_q, state_d;
    logic           tx_valid_q, tx_valid_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic           err_q, err_d;
    logic [15:0]    crc_value_q, crc_value_d;
    logic           crc_init, crc_en;
    logic [15:0]    crc;

    crc16_ibm_d8 u_crc (
        .sclk  (sclk),
        .reset (reset),
        .init  (crc_init),
        .en    (crc_en),
        .din   (s_data),
        .crc   (crc)
    );

    always_comb begin
        state_d     = state_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        err_d       = 1'b0;
        crc_value_d = crc_value_q;
        crc_init    = 1'b0;
        crc_en      = 1'b0;
        s_ready     = 1'b0;

        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (s_valid) state_d = ST_INIT;
            end
            ST_INIT: begin
                crc_init = 1'b1;
                cnt_d    = '0;
                ovf_d    = 1'b0;
                state_d  = ST_DATA;
            end
            ST_DATA: begin
                s_ready = !tx_valid_q || tx_ready;
                if (s_valid && s_ready) begin
                    tx_data_d  = s_data;
                    tx_valid_d = 1'b1;
                    crc_en     = 1'b1;
                    cnt_d      = cnt_q + CW'(1);
                    if (s_last) begin
                        state_d = ST_CRC_WAIT;
                    end else if (cnt_q == LAST_IDX) begin
                        ovf_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = ST_CRC_WAIT;
                    end
                end
            end
            ST_CRC_WAIT: begin
                // Overflowed frames drain the final byte but get no trailer.
                if (!tx_valid_q || tx_ready) begin
                    if (ovf_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        tx_data_d  = crc[7:0];
                        tx_valid_d = 1'b1;
                        state_d    = ST_CRC_LO;
                    end
                end
            end
            ST_CRC_LO: begin
                if (tx_ready) begin
                    tx_data_d  = crc[15:8];
                    tx_valid_d = 1'b1;
                    state_d    = ST_CRC_HI;
                end
            end
            ST_CRC_HI: begin
                if (tx_ready) begin
                    crc_value_d = crc;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            crc_value_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            crc_value_q <= crc_value_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign frame_err  = err_q;
    assign crc_value  = crc_value_q;

endmodule

// File: tb/tb_bq_frame_tx_seq.sv
// Bench for bq_frame_tx_seq: two instances (MAX_LEN 16 and 4) driven by directed and random frames.
module tb_bq_frame_tx_seq;

    logic        sclk = 1'b0;
    always #5 sclk = ~sclk;

    logic        reset_n   [2];
    logic [7:0]  s_data    [2];
    logic        s_valid   [2];
    logic        s_last    [2];
    logic        tx_ready  [2];
    logic        s_ready   [2];
    logic [7:0]  tx_data   [2];
    logic        tx_valid  [2];
    logic        busy      [2];
    logic        frame_done[2];
    logic        frame_err [2];
    logic [15:0] crc_value [2];

    bq_frame_tx_seq #(.MAX_LEN(16)) dut0 (
        .sclk(sclk), .reset(reset_n[0]),
        .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]), .s_ready(s_ready[0]),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .busy(busy[0]), .frame_done(frame_done[0]), .frame_err(frame_err[0]), .crc_value(crc_value[0])
    );

    bq_frame_tx_seq #(.MAX_LEN(4)) dut1 (
        .sclk(sclk), .reset(reset_n[1]),
        .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]), .s_ready(s_ready[1]),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .busy(busy[1]), .frame_done(frame_done[1]), .frame_err(frame_err[1]), .crc_value(crc_value[1])
    );

    int tests = 0;
    int fails = 0;

    // Monitor: transmitted bytes tagged with instance index, pulse counts, stall stability.
    logic [8:0]  txq[$];
    int          done_cnt[2] = '{0, 0};
    int          err_cnt[2]  = '{0, 0};
    int          overlap_cnt = 0;
    int          stall_viol  = 0;
    logic        prev_stall[2] = '{1'b0, 1'b0};
    logic [7:0]  prev_data[2]  = '{8'h00, 8'h00};

    always @(negedge sclk) begin
        for (int k = 0; k < 2; k++) begin
            if (prev_stall[k] && reset_n[k] === 1'b1 &&
                (tx_valid[k] !== 1'b1 || tx_data[k] !== prev_data[k])) stall_viol++;
            if (reset_n[k] === 1'b1 && tx_valid[k] === 1'b1 && tx_ready[k] === 1'b1)
                txq.push_back({1'(k), tx_data[k]});
            if (frame_done[k] === 1'b1) done_cnt[k]++;
            if (frame_err[k] === 1'b1) err_cnt[k]++;
            if (frame_done[k] === 1'b1 && frame_err[k] === 1'b1) overlap_cnt++;
            prev_stall[k] = (tx_valid[k] === 1'b1) && (tx_ready[k] === 1'b0) && (reset_n[k] === 1'b1);
            prev_data[k]  = tx_data[k];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference CRC straight from the bit-serial definition.
    function automatic logic [15:0] ref_crc_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = c >> 1;
            if (fb) c = c ^ 16'hA001;
        end
        return c;
    endfunction

    function automatic logic rdy(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2) == 0;
        return $urandom_range(0, 1) == 1;
    endfunction

    logic [7:0]  frm[0:63];
    logic        lst[0:63];
    int          frm_n;
    int          acc_cnt;
    logic [15:0] exp_crcv[2] = '{16'h0000, 16'h0000};

    task automatic drive(input int sel, input int mode, input bit gaps);
        int idx = 0;
        int cyc = 0;
        bit saw_err = 1'b0;
        while (idx < frm_n && !saw_err && cyc < 3000) begin
            @(posedge sclk); #1;
            s_valid[sel]  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data[sel]   = frm[idx];
            s_last[sel]   = lst[idx];
            tx_ready[sel] = rdy(mode, cyc);
            @(negedge sclk);
            if (s_valid[sel] && s_ready[sel]) idx++;
            if (frame_err[sel] === 1'b1) saw_err = 1'b1;
            cyc++;
        end
        acc_cnt = idx;
        @(posedge sclk); #1;
        s_valid[sel] = 1'b0;
        s_last[sel]  = 1'b0;
        chk("drive_budget", 32'(cyc < 3000), 32'd1);
    endtask

    task automatic drain(input int sel, input int mode);
        int cyc = 0;
        do begin
            @(posedge sclk); #1;
            tx_ready[sel] = rdy(mode, cyc);
            @(negedge sclk);
            cyc++;
        end while ((busy[sel] === 1'b1 || tx_valid[sel] === 1'b1) && cyc < 300);
        chk("drain_budget", 32'(cyc < 300), 32'd1);
    endtask

    task automatic load_base(input int copies);
        logic [7:0] base[5] = '{8'h80, 8'h00, 8'h02, 8'h0F, 8'h0B};
        frm_n = 5 * copies;
        for (int i = 0; i < frm_n; i++) begin
            frm[i] = base[i % 5];
            lst[i] = (i % 5) == 4;
        end
    endtask

    task automatic run_check(input int sel, input int mode, input bit gaps, input int max_len, input string tag);
        logic [7:0]  exp_q[$];
        logic [7:0]  got_q[$];
        logic [15:0] c = 16'hFFFF;
        int          cnt = 0;
        int          exp_done = 0;
        int          exp_err = 0;
        int          exp_acc = 0;
        int          d0 = done_cnt[sel];
        int          e0 = err_cnt[sel];
        for (int i = 0; i < frm_n; i++) begin
            exp_q.push_back(frm[i]);
            exp_acc++;
            c = ref_crc_byte(c, frm[i]);
            cnt++;
            if (lst[i]) begin
                exp_q.push_back(c[7:0]);
                exp_q.push_back(c[15:8]);
                exp_done++;
                exp_crcv[sel] = c;
                c   = 16'hFFFF;
                cnt = 0;
            end else if (cnt == max_len) begin
                exp_err++;
                break;
            end
        end
        txq.delete();
        drive(sel, mode, gaps);
        drain(sel, mode);
        repeat (2) @(negedge sclk);
        foreach (txq[i]) if (int'(txq[i][8]) == sel) got_q.push_back(txq[i][7:0]);
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        chk({tag, "_accepted"}, 32'(acc_cnt), 32'(exp_acc));
        chk({tag, "_done"}, 32'(done_cnt[sel] - d0), 32'(exp_done));
        chk({tag, "_err"}, 32'(err_cnt[sel] - e0), 32'(exp_err));
        chk({tag, "_crc_value"}, 32'(crc_value[sel]), 32'(exp_crcv[sel]));
        chk({tag, "_busy_after"}, 32'(busy[sel]), 32'd0);
    endtask

    initial begin
        int d0;
        for (int k = 0; k < 2; k++) begin
            reset_n[k] = 1'b0; s_data[k] = 8'h00; s_valid[k] = 1'b0;
            s_last[k] = 1'b0; tx_ready[k] = 1'b0;
        end

        // Reset values, with s_valid high to show reset dominates.
        repeat (3) @(posedge sclk);
        #1 s_valid[0] = 1'b1; s_valid[1] = 1'b1;
        @(posedge sclk);
        @(negedge sclk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_s_ready", k), 32'(s_ready[k]), 32'd0);
            chk($sformatf("rst%0d_tx_valid", k), 32'(tx_valid[k]), 32'd0);
            chk($sformatf("rst%0d_tx_data", k), 32'(tx_data[k]), 32'h00);
            chk($sformatf("rst%0d_busy", k), 32'(busy[k]), 32'd0);
            chk($sformatf("rst%0d_done", k), 32'(frame_done[k]), 32'd0);
            chk($sformatf("rst%0d_err", k), 32'(frame_err[k]), 32'd0);
            chk($sformatf("rst%0d_crc_value", k), 32'(crc_value[k]), 32'h0000);
        end
        @(posedge sclk); #1;
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = 1'b0; reset_n[k] = 1'b1;
        end
        repeat (2) @(posedge sclk);

        // Reference frame, always ready.
        load_base(1);
        run_check(0, 0, 1'b0, 16, "ref_rdy");
        chk("ref_rdy_crc_const", 32'(crc_value[0]), 32'h29C0);

        // Same frame with tx_ready toggling.
        run_check(0, 1, 1'b0, 16, "ref_toggle");
        chk("ref_toggle_stable", 32'(stall_viol), 32'd0);

        // Overflow on the MAX_LEN=4 instance.
        frm_n = 5;
        for (int i = 0; i < 5; i++) begin frm[i] = 8'(8'h10 + i); lst[i] = 1'b0; end
        run_check(1, 0, 1'b0, 4, "ovf4");

        // Reset while CRC_LO is presenting.
        load_base(1);
        d0 = done_cnt[0];
        txq.delete();
        drive(0, 0, 1'b0);
        @(negedge sclk);
        @(posedge sclk); #1 tx_ready[0] = 1'b0;
        @(negedge sclk);
        chk("crclo_valid", 32'(tx_valid[0]), 32'd1);
        chk("crclo_data", 32'(tx_data[0]), 32'hC0);
        @(posedge sclk); #1 reset_n[0] = 1'b0;
        @(posedge sclk); #1;
        chk("rst_mid_tx_valid", 32'(tx_valid[0]), 32'd0);
        chk("rst_mid_busy", 32'(busy[0]), 32'd0);
        chk("rst_mid_crc_value", 32'(crc_value[0]), 32'h0000);
        exp_crcv[0] = 16'h0000;
        reset_n[0] = 1'b1; tx_ready[0] = 1'b1;
        repeat (4) @(negedge sclk);
        chk("rst_mid_bytes", 32'(txq.size()), 32'd5);
        chk("rst_mid_no_done", 32'(done_cnt[0] - d0), 32'd0);
        run_check(0, 0, 1'b0, 16, "after_rst");

        // Back-to-back frames with s_valid held.
        load_base(2);
        run_check(0, 0, 1'b0, 16, "b2b");

        // Random frames, including overflow lengths, random ready and valid gaps.
        for (int t = 0; t < 24; t++) begin
            int sel;
            int ml;
            int len;
            sel = (t < 14) ? 0 : 1;
            ml  = (sel == 0) ? 16 : 4;
            len = $urandom_range(1, ml + 2);
            for (int i = 0; i < len; i++) begin
                frm[i] = 8'($urandom);
                lst[i] = 1'b0;
            end
            if (len <= ml) lst[len-1] = 1'b1;
            frm_n = len;
            run_check(sel, $urandom_range(0, 2), 1'($urandom_range(0, 1)), ml, $sformatf("rnd%0d", t));
        end

        chk("stall_stable_all", 32'(stall_viol), 32'd0);
        chk("done_err_exclusive", 32'(overlap_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
